// File: rtl/cla_share_arbiter.sv
// Two-requester round-robin front end for a registered 4-bit carry-lookahead adder (operand stage -> CLA -> result stage).
// Optional grant counters are compiled in when CLA_ARB_STATS_EN is defined.
module cla_share_arbiter #(
  parameter int DATA_W = 4,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r0_cin,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic              r1_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_sum,
  output logic              out_id
`ifdef CLA_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gnt0_cnt,
  output logic [STAT_W-1:0] gnt1_cnt
`endif
);

  if (DATA_W != 4 || STAT_W < 1) begin : g_param_check
    $error("cla_share_arbiter supports DATA_W=4 and STAT_W>=1 only");
  end

  // Flat two-level lookahead: every carry is a sum of products of g, p and cin.
  function automatic logic [DATA_W:0] cla_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              cin);
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W:0]   c;
    logic              prop;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DATA_W; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
    return {c[DATA_W], p ^ c[DATA_W-1:0]};
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              cin_p1;
  logic              id_p1;
  logic              rr_ptr;
  logic              adv1;
  logic              adv2;
  logic              gnt0;
  logic              gnt1;

  always_comb begin
    adv2 = !out_valid || out_ready;
    adv1 = !vld_p1 || adv2;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && adv1) begin
      if (r0_valid && (!r1_valid || !rr_ptr)) gnt0 = 1'b1;
      else if (r1_valid)                      gnt1 = 1'b1;
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  // Stage 1: operand register (data path carries no reset)
  always_ff @(posedge clk) begin
    if (gnt0 || gnt1) begin
      a_p1   <= gnt1 ? r1_a   : r0_a;
      b_p1   <= gnt1 ? r1_b   : r0_b;
      cin_p1 <= gnt1 ? r1_cin : r0_cin;
      id_p1  <= gnt1;
    end
  end

  // Stage 2: result register plus control state
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= gnt0 || gnt1;
      // Next contest favours the side that did not just win.
      if (gnt0 || gnt1) rr_ptr <= gnt0;
      if (adv2) begin
        out_valid <= vld_p1;
        out_sum   <= cla_add(a_p1, b_p1, cin_p1);
        out_id    <= id_p1;
      end
    end
  end

`ifdef CLA_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (gnt0) gnt0_cnt <= gnt0_cnt + 1'b1;
      if (gnt1) gnt1_cnt <= gnt1_cnt + 1'b1;
    end
  end
`endif

endmodule
